act_vector_streamer: RTL and testbench



---
 rtl/act_vector_streamer.sv | 119 +++++++++++
 tb/tb_act_vector_streamer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_vector_streamer.sv
// Captures a layer's parallel float32 activation vector and streams it one word per
// cycle over valid/ready with index and last tags. Define ACT_SKIP_ZERO_EN to skip +0 words.
module act_vector_streamer #(
    parameter int N_IN  = 30,
    parameter int DW    = 32,
    parameter int IDX_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [N_IN*DW-1:0]   act_flat,
    output logic                 busy,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [DW-1:0]        tx_data,
    output logic [IDX_W-1:0]     tx_idx,
    output logic                 tx_last,
    output logic                 drop_err
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic                drop_q, drop_d;
    logic [N_IN*DW-1:0]  buf_q;
    logic                capture;
    logic                at_last;
    logic [IDX_W-1:0]    first_ptr;
    logic [IDX_W-1:0]    next_ptr;
    logic [DW-1:0]       data_mux;

`ifdef ACT_SKIP_ZERO_EN
    // Lowest element at or after start that is not +0; the final element is always sent.
    function automatic logic [IDX_W-1:0] next_sent(input logic [N_IN*DW-1:0] v, input int start);
        logic [IDX_W-1:0] result;
        result = LAST_IDX;
        for (int k = N_IN - 2; k >= 0; k--) begin
            if (k >= start && v[k*DW +: DW] != '0) result = IDX_W'(k);
        end
        return result;
    endfunction

    assign first_ptr = next_sent(act_flat, 0);
    assign next_ptr  = next_sent(buf_q, int'(ptr_q) + 1);
`else
    assign first_ptr = '0;
    assign next_ptr  = ptr_q + 1'b1;
`endif

    assign at_last = (ptr_q == LAST_IDX);

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        drop_d  = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    capture = 1'b1;
                    ptr_d   = first_ptr;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (tx_ready && at_last) begin
                    if (load) begin
                        capture = 1'b1;
                        ptr_d   = first_ptr;
                    end else begin
                        ptr_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
                    if (tx_ready) ptr_d = next_ptr;
                    drop_d = load;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            drop_q  <= drop_d;
        end
    end

    // NOTE: the capture buffer is deliberately not reset; outputs are gated by state, so its contents never leak.
    always_ff @(posedge clk) begin
        if (capture) buf_q <= act_flat;
    end

    always_comb begin
        data_mux = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (state_q == SEND && ptr_q == IDX_W'(k)) data_mux = buf_q[k*DW +: DW];
        end
    end

    assign busy     = (state_q == SEND);
    assign tx_valid = (state_q == SEND);
    assign tx_data  = data_mux;
    assign tx_idx   = ptr_q;
    assign tx_last  = (state_q == SEND) && at_last;
    assign drop_err = drop_q;

endmodule

// File: tb/tb_act_vector_streamer.sv
// Randomized self-checking bench for act_vector_streamer against a queue-of-beats reference model.
// Honours ACT_SKIP_ZERO_EN in the model and adds the zero-skip scenario when it is defined.
module tb_act_vector_streamer;

    localparam int N_IN  = 30;
    localparam int DW    = 32;
    localparam int IDX_W = 6;
    localparam int OW    = DW + IDX_W + 4;

    logic                clk;
    logic                rst_n;
    logic                load;
    logic [N_IN*DW-1:0]  act_flat;
    logic                busy;
    logic                tx_valid;
    logic                tx_ready;
    logic [DW-1:0]       tx_data;
    logic [IDX_W-1:0]    tx_idx;
    logic                tx_last;
    logic                drop_err;

    act_vector_streamer #(.N_IN(N_IN), .DW(DW), .IDX_W(IDX_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .act_flat (act_flat),
        .busy     (busy),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_idx   (tx_idx),
        .tx_last  (tx_last),
        .drop_err (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [DW-1:0]    data;
        logic             last;
    } beat_t;

    beat_t exp_q[$];
    logic  exp_drop;
    int    total;
    int    bad;

    wire [OW-1:0] obs = {busy, tx_valid, tx_data, tx_idx, tx_last, drop_err};

    function automatic logic [OW-1:0] expected_obs();
        if (exp_q.size() == 0) return {2'b00, {DW{1'b0}}, {IDX_W{1'b0}}, 1'b0, exp_drop};
        return {2'b11, exp_q[0].data, exp_q[0].idx, exp_q[0].last, exp_drop};
    endfunction

    // The beats a loaded vector must produce, in order.
    function automatic void push_vector(input logic [N_IN*DW-1:0] v);
        beat_t b;
        logic  skip;
        for (int k = 0; k < N_IN; k++) begin
            skip = 1'b0;
`ifdef ACT_SKIP_ZERO_EN
            skip = (v[k*DW +: DW] == 32'h0) && (k != N_IN - 1);
`endif
            if (!skip) begin
                b.idx  = IDX_W'(k);
                b.data = v[k*DW +: DW];
                b.last = (k == N_IN - 1);
                exp_q.push_back(b);
            end
        end
    endfunction

    function automatic logic [N_IN*DW-1:0] rand_vec();
        logic [N_IN*DW-1:0] v;
        int unsigned r;
        for (int k = 0; k < N_IN; k++) begin
            r = $urandom_range(0, 7);
            v[k*DW +: DW] = (r == 0) ? 32'h0 : (r == 1) ? 32'h8000_0000 : $urandom;
        end
        return v;
    endfunction

    // Drive one cycle from a negedge, advance the model across the posedge, return at the next negedge.
    task automatic step(input logic ld, input logic [N_IN*DW-1:0] v, input logic rdy);
        load     = ld;
        act_flat = v;
        tx_ready = rdy;
        if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
        exp_drop = 1'b0;
        if (ld) begin
            if (exp_q.size() == 0) push_vector(v);
            else exp_drop = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        load     = 1'b0;
        tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        exp_q.delete();
        exp_drop = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== expected_obs()) begin
            bad++;
            $display("FAIL reset: got %h want %h", obs, expected_obs());
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [N_IN*DW-1:0] v;
        for (int k = 0; k < N_IN; k++) v[k*DW +: DW] = 32'h3F80_0000 + k;
        step(1'b1, v, 1'b1);
        for (int c = 0; c <= N_IN; c++) begin
            total++;
            if (obs !== expected_obs()) begin
                bad++;
                $display("FAIL basic cyc %0d: got %h want %h", c, obs, expected_obs());
            end
            if (c < N_IN) step(1'b0, '0, 1'b1);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        step(1'b1, rand_vec(), 1'b0);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 400) begin
            step(1'b0, '0, (cyc % 4 == 0) || (cyc % 4 == 3));
            total++;
            if (obs !== expected_obs()) begin
                bad++;
                $display("FAIL backpressure cyc %0d: got %h want %h", cyc, obs, expected_obs());
            end
            cyc++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL backpressure timeout: left %0d want 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [N_IN*DW-1:0] b;
        logic done_b;
        int   cyc;
        b      = rand_vec();
        done_b = 1'b0;
        step(1'b1, rand_vec(), 1'b1);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 500) begin
            if (!done_b && exp_q.size() == 1) begin
                step(1'b1, b, 1'b1);
                done_b = 1'b1;
            end else begin
                step(1'b0, '0, 1'($urandom_range(0, 1)));
            end
            total++;
            if (obs !== expected_obs()) begin
                bad++;
                $display("FAIL back_to_back cyc %0d: got %h want %h", cyc, obs, expected_obs());
            end
            cyc++;
        end
        total++;
        if (exp_q.size() != 0 || !done_b) begin
            bad++;
            $display("FAIL back_to_back timeout: left %0d done %0d want 0 1", exp_q.size(), done_b);
        end
    endtask

    task automatic test_rejected_load();
        int cyc;
        step(1'b1, rand_vec(), 1'b1);
        cyc = 0;
        while (exp_q.size() != 0 && exp_q[0].idx < 10 && cyc < 100) begin
            step(1'b0, '0, 1'b1);
            cyc++;
        end
        step(1'b1, rand_vec(), 1'b0);
        total++;
        if (obs !== expected_obs() || drop_err !== 1'b1) begin
            bad++;
            $display("FAIL rejected pulse: got %h want %h", obs, expected_obs());
        end
        step(1'b0, '0, 1'b0);
        total++;
        if (obs !== expected_obs() || drop_err !== 1'b0) begin
            bad++;
            $display("FAIL rejected clear: got %h want %h", obs, expected_obs());
        end
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            step(1'b0, '0, 1'b1);
            total++;
            if (obs !== expected_obs()) begin
                bad++;
                $display("FAIL rejected tail cyc %0d: got %h want %h", cyc, obs, expected_obs());
            end
            cyc++;
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        step(1'b1, rand_vec(), 1'b1);
        cyc = 0;
        while (exp_q.size() != 0 && exp_q[0].idx < 15 && cyc < 100) begin
            step(1'b0, '0, 1'b1);
            cyc++;
        end
        rst_n    = 1'b0;
        tx_ready = 1'b1;
        @(posedge clk);
        exp_q.delete();
        exp_drop = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if (obs !== expected_obs()) begin
            bad++;
            $display("FAIL reset_mid: got %h want %h", obs, expected_obs());
        end
        step(1'b1, rand_vec(), 1'b1);
        cyc = 0;
        while (cyc < N_IN + 2) begin
            total++;
            if (obs !== expected_obs()) begin
                bad++;
                $display("FAIL reset_mid restart cyc %0d: got %h want %h", cyc, obs, expected_obs());
            end
            step(1'b0, '0, 1'b1);
            cyc++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 9) == 0, rand_vec(), $urandom_range(0, 2) != 0);
            total++;
            if (obs !== expected_obs()) begin
                bad++;
                $display("FAIL random cyc %0d: got %h want %h", c, obs, expected_obs());
            end
        end
    endtask

`ifdef ACT_SKIP_ZERO_EN
    task automatic test_skip_zero();
        logic [N_IN*DW-1:0] v;
        int beats;
        v = '0;
        v[3*DW +: DW] = 32'h4000_0000;
        v[7*DW +: DW] = 32'h8000_0000;
        step(1'b1, v, 1'b1);
        beats = 0;
        while (beats < 5) begin
            total++;
            if (obs !== expected_obs()) begin
                bad++;
                $display("FAIL skip_zero beat %0d: got %h want %h", beats, obs, expected_obs());
            end
            step(1'b0, '0, 1'b1);
            beats++;
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        total    = 0;
        bad      = 0;
        exp_drop = 1'b0;
        rst_n    = 1'b0;
        load     = 1'b0;
        tx_ready = 1'b0;
        act_flat = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_rejected_load();
        test_reset_mid();
        test_random();
`ifdef ACT_SKIP_ZERO_EN
        test_skip_zero();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
